// File: rtl/fpu_in_mq.sv
// FPU request input queue: packs two-beat crossbar requests into entries and dispatches them in order to NPIPE pipes.
// Registered active-low per-pipe clock enables are derived from per-pipe occupancy. Protocol and overflow errors are sticky.
module fpu_in_mq #(
  parameter int DEPTH = 16,
  parameter int NPIPE = 3,
  parameter int DW    = 64,
  parameter int OPW   = 8,
  parameter int IDW   = 5
) (
  input  logic                   rclk,
  input  logic                   grst,
  input  logic                   in_vld,
  input  logic                   in_beat_b,
  input  logic                   in_two_src,
  input  logic [NPIPE-1:0]       in_pipe_sel,
  input  logic [IDW-1:0]         in_id,
  input  logic [OPW-1:0]         in_op,
  input  logic [DW-1:0]          in_data,
  output logic                   in_rdy,
  input  logic [NPIPE-1:0]       pipe_step,
  input  logic [NPIPE-1:0]       pipe_active,
  output logic                   out_req,
  output logic [NPIPE-1:0]       out_pipe,
  output logic [IDW-1:0]         out_id,
  output logic [OPW-1:0]         out_op,
  output logic [DW-1:0]          out_src1,
  output logic [DW-1:0]          out_src2,
  output logic [NPIPE-1:0]       clken_l,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   proto_err,
  output logic                   ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, WAIT_B = 1'b1} state_t;

  state_t state_q, state_d;

  logic [NPIPE-1:0] hold_pipe_q, hold_pipe_d;
  logic [IDW-1:0]   hold_id_q, hold_id_d;
  logic [OPW-1:0]   hold_op_q, hold_op_d;
  logic [DW-1:0]    hold_src1_q, hold_src1_d;

  logic [NPIPE-1:0] mem_pipe [DEPTH];
  logic [IDW-1:0]   mem_id   [DEPTH];
  logic [OPW-1:0]   mem_op   [DEPTH];
  logic [DW-1:0]    mem_src1 [DEPTH];
  logic [DW-1:0]    mem_src2 [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    pcnt_q [NPIPE];
  logic [CW-1:0]    pcnt_d [NPIPE];
  logic [NPIPE-1:0] pcnt_nz;
  logic [NPIPE-1:0] clken_l_q, clken_l_d;
  logic             proto_q, proto_d;
  logic             ovf_q, ovf_d;

  logic             is_a, is_b, pop, sel_onehot;
  logic             wr_en, hold_ld, proto_set, ovf_set;
  logic [NPIPE-1:0] wr_pipe;
  logic [IDW-1:0]   wr_id;
  logic [OPW-1:0]   wr_op;
  logic [DW-1:0]    wr_src1, wr_src2;

  assign is_a       = in_vld & ~in_beat_b;
  assign is_b       = in_vld & in_beat_b;
  assign in_rdy     = (cnt_q != CW'(DEPTH));
  assign out_req    = (cnt_q != '0);
  assign sel_onehot = (in_pipe_sel != '0) && ((in_pipe_sel & (in_pipe_sel - 1'b1)) == '0);

  assign out_pipe = mem_pipe[rd_ptr_q];
  assign out_id   = mem_id[rd_ptr_q];
  assign out_op   = mem_op[rd_ptr_q];
  assign out_src1 = mem_src1[rd_ptr_q];
  assign out_src2 = mem_src2[rd_ptr_q];
  assign pop      = out_req & |(pipe_step & out_pipe);

  // Assembly FSM: state register
  always_ff @(posedge rclk) begin
    if (grst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Assembly FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (is_a && in_rdy) state_d = in_two_src ? WAIT_B : IDLE;
      end
      WAIT_B: begin
        if (is_a && in_rdy) state_d = in_two_src ? WAIT_B : IDLE;
        else if (is_b)      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Assembly FSM: outputs. Violations are flagged even when the beat is also dropped for lack of space.
  always_comb begin
    wr_en     = 1'b0;
    hold_ld   = 1'b0;
    proto_set = 1'b0;
    ovf_set   = 1'b0;
    wr_pipe   = in_pipe_sel;
    wr_id     = in_id;
    wr_op     = in_op;
    wr_src1   = in_data;
    wr_src2   = '0;
    unique case (state_q)
      IDLE: begin
        if (is_a) begin
          if (!in_rdy) begin
            ovf_set = 1'b1;
          end else begin
            proto_set = ~sel_onehot;
            hold_ld   = in_two_src;
            wr_en     = ~in_two_src;
          end
        end else if (is_b) begin
          proto_set = 1'b1;
          ovf_set   = ~in_rdy;
        end
      end
      WAIT_B: begin
        if (is_a) begin
          proto_set = 1'b1;
          if (!in_rdy) begin
            ovf_set = 1'b1;
          end else begin
            hold_ld = in_two_src;
            wr_en   = ~in_two_src;
          end
        end else if (is_b) begin
          if (in_rdy || pop) begin
            wr_en   = 1'b1;
            wr_pipe = hold_pipe_q;
            wr_id   = hold_id_q;
            wr_op   = hold_op_q;
            wr_src1 = hold_src1_q;
            wr_src2 = in_data;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    hold_pipe_d = hold_ld ? in_pipe_sel : hold_pipe_q;
    hold_id_d   = hold_ld ? in_id       : hold_id_q;
    hold_op_d   = hold_ld ? in_op       : hold_op_q;
    hold_src1_d = hold_ld ? in_data     : hold_src1_q;
    wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d       = cnt_q + CW'(wr_en) - CW'(pop);
    proto_d     = proto_q | proto_set;
    ovf_d       = ovf_q | ovf_set;
    for (int i = 0; i < NPIPE; i++) begin
      pcnt_d[i]  = pcnt_q[i] + CW'(wr_en & wr_pipe[i]) - CW'(pop & out_pipe[i]);
      pcnt_nz[i] = (pcnt_q[i] != '0);
    end
    // The incoming A beat wakes its pipe a cycle before the entry is counted.
    clken_l_d = ~(pipe_active | pcnt_nz | ({NPIPE{is_a}} & in_pipe_sel));
  end

  always_ff @(posedge rclk) begin
    if (grst) begin
      hold_pipe_q <= '0;
      hold_id_q   <= '0;
      hold_op_q   <= '0;
      hold_src1_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      clken_l_q   <= '0;
      proto_q     <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < NPIPE; i++) pcnt_q[i] <= '0;
    end else begin
      hold_pipe_q <= hold_pipe_d;
      hold_id_q   <= hold_id_d;
      hold_op_q   <= hold_op_d;
      hold_src1_q <= hold_src1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      clken_l_q   <= clken_l_d;
      proto_q     <= proto_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < NPIPE; i++) pcnt_q[i] <= pcnt_d[i];
    end
  end

  // Entry storage carries no reset; occupancy qualifies every read.
  always_ff @(posedge rclk) begin
    if (wr_en) begin
      mem_pipe[wr_ptr_q] <= wr_pipe;
      mem_id[wr_ptr_q]   <= wr_id;
      mem_op[wr_ptr_q]   <= wr_op;
      mem_src1[wr_ptr_q] <= wr_src1;
      mem_src2[wr_ptr_q] <= wr_src2;
    end
  end

  assign cnt       = cnt_q;
  assign clken_l   = clken_l_q;
  assign proto_err = proto_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_fpu_in_mq.sv
// Bench for fpu_in_mq: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_fpu_in_mq;
  localparam int DEPTH = 16;
  localparam int NPIPE = 3;
  localparam int DW    = 64;
  localparam int OPW   = 8;
  localparam int IDW   = 5;

  logic             rclk = 1'b0;
  logic             grst, in_vld, in_beat_b, in_two_src;
  logic [NPIPE-1:0] in_pipe_sel, pipe_step, pipe_active;
  logic [IDW-1:0]   in_id;
  logic [OPW-1:0]   in_op;
  logic [DW-1:0]    in_data;
  logic             in_rdy, out_req, proto_err, ovf_err;
  logic [NPIPE-1:0] out_pipe, clken_l;
  logic [IDW-1:0]   out_id;
  logic [OPW-1:0]   out_op;
  logic [DW-1:0]    out_src1, out_src2;
  logic [4:0]       cnt;

  always #5 rclk = ~rclk;

  fpu_in_mq #(.DEPTH(DEPTH), .NPIPE(NPIPE), .DW(DW), .OPW(OPW), .IDW(IDW)) dut (
    .rclk(rclk), .grst(grst), .in_vld(in_vld), .in_beat_b(in_beat_b), .in_two_src(in_two_src),
    .in_pipe_sel(in_pipe_sel), .in_id(in_id), .in_op(in_op), .in_data(in_data), .in_rdy(in_rdy),
    .pipe_step(pipe_step), .pipe_active(pipe_active), .out_req(out_req), .out_pipe(out_pipe),
    .out_id(out_id), .out_op(out_op), .out_src1(out_src1), .out_src2(out_src2),
    .clken_l(clken_l), .cnt(cnt), .proto_err(proto_err), .ovf_err(ovf_err)
  );

  typedef struct packed {
    logic [NPIPE-1:0] pipe;
    logic [IDW-1:0]   id;
    logic [OPW-1:0]   op;
    logic [DW-1:0]    s1;
    logic [DW-1:0]    s2;
  } ent_t;

  // Reference model: the queue contents themselves, plus the pending half-packet.
  ent_t             mq[$];
  ent_t             hold;
  bit               waiting = 1'b0;
  bit               m_proto = 1'b0;
  bit               m_ovf   = 1'b0;
  logic [NPIPE-1:0] m_clken = '0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge rclk) begin
    logic [NPIPE-1:0] nz;
    bit   rdy, pop, wr;
    ent_t e;
    nz = '0;
    foreach (mq[k]) nz |= mq[k].pipe;
    rdy = (mq.size() != DEPTH);
    pop = (mq.size() != 0) && ((pipe_step & mq[0].pipe) != '0);
    wr  = 1'b0;
    e   = '0;
    if (grst) begin
      mq.delete();
      waiting = 1'b0;
      m_proto = 1'b0;
      m_ovf   = 1'b0;
      m_clken = '0;
    end else begin
      m_clken = ~(pipe_active | nz | ((in_vld && !in_beat_b) ? in_pipe_sel : '0));
      if (in_vld && !in_beat_b) begin
        if (waiting) m_proto = 1'b1;
        if (!rdy) begin
          m_ovf = 1'b1;
        end else begin
          if (!$onehot(in_pipe_sel)) m_proto = 1'b1;
          e.pipe = in_pipe_sel;
          e.id   = in_id;
          e.op   = in_op;
          e.s1   = in_data;
          e.s2   = '0;
          if (in_two_src) begin
            hold    = e;
            waiting = 1'b1;
          end else begin
            wr      = 1'b1;
            waiting = 1'b0;
          end
        end
      end else if (in_vld) begin
        if (!waiting) begin
          m_proto = 1'b1;
          if (!rdy) m_ovf = 1'b1;
        end else begin
          waiting = 1'b0;
          if (rdy || pop) begin
            e    = hold;
            e.s2 = in_data;
            wr   = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (wr) mq.push_back(e);
    end
  end

  always @(negedge rclk) begin
    chk("cnt", 64'(cnt), 64'(mq.size()));
    chk("in_rdy", 64'(in_rdy), 64'(mq.size() != DEPTH));
    chk("out_req", 64'(out_req), 64'(mq.size() != 0));
    chk("clken_l", 64'(clken_l), 64'(m_clken));
    chk("proto_err", 64'(proto_err), 64'(m_proto));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    if (mq.size() != 0) begin
      chk("out_pipe", 64'(out_pipe), 64'(mq[0].pipe));
      chk("out_id", 64'(out_id), 64'(mq[0].id));
      chk("out_op", 64'(out_op), 64'(mq[0].op));
      chk("out_src1", out_src1, mq[0].s1);
      chk("out_src2", out_src2, mq[0].s2);
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic drive_a(input logic [IDW-1:0] id, input logic [OPW-1:0] op, input logic two,
                         input logic [NPIPE-1:0] sel, input logic [DW-1:0] d);
    in_vld = 1'b1; in_beat_b = 1'b0; in_two_src = two;
    in_pipe_sel = sel; in_id = id; in_op = op; in_data = d;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic drive_b(input logic [DW-1:0] d);
    in_vld = 1'b1; in_beat_b = 1'b1; in_data = d;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic do_reset();
    grst = 1'b1;
    tick();
    grst = 1'b0;
  endtask

  initial begin
    logic [NPIPE-1:0] sel;
    int r;
    grst = 1'b1; in_vld = 1'b0; in_beat_b = 1'b0; in_two_src = 1'b0; in_pipe_sel = '0;
    in_id = '0; in_op = '0; in_data = '0; pipe_step = '0; pipe_active = '0;
    repeat (3) tick();
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_clken_l", 64'(clken_l), 64'd0);
    chk("rst_errs", 64'({proto_err, ovf_err}), 64'd0);
    grst = 1'b0;
    tick();
    chk("idle_clken_l", 64'(clken_l), 64'b111);

    // Single-source op
    drive_a(5'd3, 8'h41, 1'b0, 3'b001, 64'hDEAD_BEEF_0000_1111);
    chk("t1_out_req", 64'(out_req), 64'd1);
    chk("t1_src2", out_src2, 64'd0);
    chk("t1_pipe", 64'(out_pipe), 64'b001);
    chk("t1_id", 64'(out_id), 64'd3);
    pipe_step = 3'b001;
    tick();
    pipe_step = '0;
    chk("t1_pop_req", 64'(out_req), 64'd0);
    chk("t1_pop_cnt", 64'(cnt), 64'd0);

    // Two-source op with a 5-cycle stall between beats
    drive_a(5'd7, 8'h22, 1'b1, 3'b010, 64'h1111_2222_3333_4444);
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_cnt", 64'(cnt), 64'd0);
      tick();
    end
    drive_b(64'h5555_6666_7777_8888);
    chk("t2_cnt", 64'(cnt), 64'd1);
    chk("t2_id", 64'(out_id), 64'd7);
    chk("t2_src1", out_src1, 64'h1111_2222_3333_4444);
    chk("t2_src2", out_src2, 64'h5555_6666_7777_8888);
    pipe_step = 3'b010;
    tick();
    pipe_step = '0;

    // Fill, overflow, drain, then wrap the pointers
    for (int i = 0; i < 16; i++) drive_a(IDW'(i), OPW'(i), 1'b0, 3'b100, DW'(i));
    chk("t3_full_cnt", 64'(cnt), 64'd16);
    chk("t3_full_rdy", 64'(in_rdy), 64'd0);
    drive_a(5'd17, 8'h17, 1'b0, 3'b100, 64'd17);
    chk("t3_ovf", 64'(ovf_err), 64'd1);
    chk("t3_ovf_cnt", 64'(cnt), 64'd16);
    pipe_step = 3'b100;
    tick();
    chk("t3_pop_rdy", 64'(in_rdy), 64'd1);
    for (int i = 1; i < 16; i++) begin
      chk("t3_order_id", 64'(out_id), 64'(i));
      tick();
    end
    chk("t3_drained", 64'(cnt), 64'd0);
    pipe_step = 3'b001;
    for (int k = 0; k < 40; k++) begin
      drive_a(IDW'(k % 32), OPW'(k), 1'b0, 3'b001, DW'(k));
      chk("t3_wrap_id", 64'(out_id), 64'(k % 32));
      chk("t3_wrap_cnt", 64'(cnt), 64'd1);
    end
    tick();
    pipe_step = '0;

    // Protocol errors
    do_reset();
    drive_b(64'd5);
    chk("t4_proto", 64'(proto_err), 64'd1);
    chk("t4_cnt", 64'(cnt), 64'd0);
    drive_a(5'd9, 8'h01, 1'b1, 3'b001, 64'hAAAA);
    drive_a(5'd10, 8'h02, 1'b1, 3'b001, 64'hBBBB);
    drive_b(64'hCCCC);
    chk("t4_cnt1", 64'(cnt), 64'd1);
    chk("t4_id", 64'(out_id), 64'd10);
    chk("t4_src1", out_src1, 64'hBBBB);
    chk("t4_src2", out_src2, 64'hCCCC);
    pipe_step = 3'b001;
    tick();
    pipe_step = '0;

    // Clock enables
    do_reset();
    tick();
    chk("t5_clk_idle", 64'(clken_l), 64'b111);
    drive_a(5'd4, 8'h03, 1'b0, 3'b100, 64'd0);
    chk("t5_clk_wake", 64'(clken_l), 64'b011);
    tick();
    chk("t5_clk_pcnt", 64'(clken_l), 64'b011);
    pipe_active = 3'b100; pipe_step = 3'b100;
    tick();
    pipe_step = '0;
    tick();
    chk("t5_clk_active", 64'(clken_l), 64'b011);
    pipe_active = '0;
    tick();
    chk("t5_clk_off", 64'(clken_l), 64'b111);

    // Reset mid-packet with a non-empty queue
    do_reset();
    for (int i = 0; i < 5; i++) drive_a(IDW'(i), 8'h10, 1'b0, 3'b010, DW'(i));
    drive_a(5'd20, 8'h20, 1'b1, 3'b010, 64'd20);
    chk("t6_pre_cnt", 64'(cnt), 64'd5);
    do_reset();
    chk("t6_cnt", 64'(cnt), 64'd0);
    chk("t6_req", 64'(out_req), 64'd0);
    chk("t6_errs", 64'({proto_err, ovf_err}), 64'd0);
    drive_b(64'd1);
    chk("t6_proto", 64'(proto_err), 64'd1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      grst   = ($urandom_range(0, 599) == 0);
      in_vld = ($urandom_range(0, 9) < 6);
      in_beat_b = waiting ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0);
      in_two_src = $urandom_range(0, 1);
      r = $urandom_range(0, 15);
      sel = 3'b001 << (r % 3);
      if (r == 0) sel = 3'b011;
      in_pipe_sel = sel;
      in_id   = IDW'($urandom);
      in_op   = OPW'($urandom);
      in_data = {$urandom, $urandom};
      if (((c / 400) % 2) == 0) pipe_step = NPIPE'($urandom);
      else pipe_step = ($urandom_range(0, 5) == 0) ? NPIPE'($urandom) : '0;
      pipe_active = NPIPE'($urandom);
      tick();
    end
    grst = 1'b0; in_vld = 1'b0; pipe_step = '0; pipe_active = '0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
